// File: rtl/mem_port_arbiter_if.sv
// Bundles the requestor handshakes and the shared memory port of mem_port_arbiter.
// slave is the arbiter's view; master is the view of the requestors plus the memory.
interface mem_port_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS*STRB_W-1:0] req_wstrb;
    logic [NUM_PORTS*STRB_W-1:0] req_rstrb;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [STRB_W-1:0]           mem_write;
    logic [STRB_W-1:0]           mem_read;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb, req_rstrb, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb, req_rstrb, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of NUM_PORTS valid/ready requestors onto one byte-strobed memory port.
// One request in flight: IDLE grants, ACCESS drives memory for MEM_LAT cycles, RESP pulses rsp_valid.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_LAT   = 1
) (
    input  logic               clk,
    input  logic               nrst,
    mem_port_arbiter_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t               state_r;
    logic [PTR_W-1:0]     ptr_r;
    logic [PTR_W-1:0]     grant_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [DATA_W-1:0]    mem_wdata_r;
    logic [STRB_W-1:0]    mem_write_r;
    logic [STRB_W-1:0]    mem_read_r;
    logic [NUM_PORTS-1:0] rsp_valid_r;
    logic [DATA_W-1:0]    rsp_rdata_r;

    logic [PTR_W:0]       sum_s;
    logic [PTR_W-1:0]     idx_s;
    logic                 hit_s;
    logic [PTR_W-1:0]     grant_s;
    logic                 found_s;
    logic [ADDR_W-1:0]    addr_s;
    logic [DATA_W-1:0]    wdata_s;
    logic [STRB_W-1:0]    wstrb_s;
    logic [STRB_W-1:0]    rstrb_s;
    logic [NUM_PORTS-1:0] ready_s;
    logic                 active_s;

    function automatic logic [DATA_W-1:0] lane_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < STRB_W; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    // Round-robin search: first valid port at or above the pointer, wrapping.
    always_comb begin
        grant_s = ptr_r;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum_s   = {1'b0, ptr_r} + (PTR_W+1)'(i);
            idx_s   = (sum_s >= (PTR_W+1)'(NUM_PORTS)) ?
                      PTR_W'(sum_s - (PTR_W+1)'(NUM_PORTS)) : sum_s[PTR_W-1:0];
            hit_s   = ~found_s & bus.req_valid[idx_s];
            grant_s = hit_s ? idx_s : grant_s;
            found_s = found_s | hit_s;
        end
    end

    // Payload of the port being granted this cycle.
    always_comb begin
        addr_s  = '0;
        wdata_s = '0;
        wstrb_s = '0;
        rstrb_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            addr_s  = (grant_s == PTR_W'(i)) ? bus.req_addr[i*ADDR_W +: ADDR_W]  : addr_s;
            wdata_s = (grant_s == PTR_W'(i)) ? bus.req_wdata[i*DATA_W +: DATA_W] : wdata_s;
            wstrb_s = (grant_s == PTR_W'(i)) ? bus.req_wstrb[i*STRB_W +: STRB_W] : wstrb_s;
            rstrb_s = (grant_s == PTR_W'(i)) ? bus.req_rstrb[i*STRB_W +: STRB_W] : rstrb_s;
        end
        active_s = (wstrb_s != '0) || (rstrb_s != '0);
    end

    // Same-cycle accept; held low during reset so every output reads 0 immediately.
    always_comb begin
        ready_s = '0;
        if ((state_r == ST_IDLE) && found_s && !nrst) begin
            ready_s[grant_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // Arbitration FSM with registered memory and response outputs.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            grant_r     <= '0;
            cnt_r       <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_write_r <= '0;
            mem_read_r  <= '0;
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_r     <= grant_s;
                        cnt_r       <= '0;
                        mem_addr_r  <= active_s ? addr_s  : '0;
                        mem_wdata_r <= active_s ? wdata_s : '0;
                        mem_write_r <= wstrb_s;
                        // A write wins over a read when both strobes are set.
                        mem_read_r  <= (wstrb_s != '0) ? '0 : rstrb_s;
                        state_r     <= ST_ACCESS;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == CNT_LAST) begin
                        rsp_rdata_r          <= bus.mem_rdata & lane_mask(mem_read_r);
                        rsp_valid_r[grant_r] <= 1'b1;
                        mem_addr_r           <= '0;
                        mem_wdata_r          <= '0;
                        mem_write_r          <= '0;
                        mem_read_r           <= '0;
                        state_r              <= ST_RESP;
                    end else begin
                        cnt_r                <= cnt_r + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= '0;
                    ptr_r       <= (grant_r == PTR_LAST) ? '0 : grant_r + 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    mem_addr_r  <= '0;
                    mem_wdata_r <= '0;
                    mem_write_r <= '0;
                    mem_read_r  <= '0;
                    rsp_valid_r <= '0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_write = mem_write_r;
    assign bus.mem_read  = mem_read_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=1 and a MEM_LAT=3 instance, table-driven transfers,
// hand-written round-robin and mid-access reset sequences, responses checked via a scoreboard.
module tb_mem_port_arbiter;
    logic clk;
    logic nrst;

    mem_port_arbiter_if #(.NUM_PORTS(2), .DATA_W(32), .ADDR_W(32)) if1 ();
    mem_port_arbiter_if #(.NUM_PORTS(2), .DATA_W(32), .ADDR_W(32)) if3 ();

    mem_port_arbiter #(.NUM_PORTS(2), .DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) dut1 (
        .clk (clk),
        .nrst(nrst),
        .bus (if1.slave)
    );

    mem_port_arbiter #(.NUM_PORTS(2), .DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) dut3 (
        .clk (clk),
        .nrst(nrst),
        .bus (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        int          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  rstrb;
        logic [31:0] mrd;
        logic [3:0]  exp_w;
        logic [3:0]  exp_r;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          sel;
        int          port;
        logic [31:0] rdata;
        int          due;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[10];
    int   n_checks;
    int   n_fail;
    int   cycle;

    function automatic logic [1:0] onehot(input int p);
        logic [1:0] v;
        v = 2'b01 << p;
        return v;
    endfunction

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic get_out(input int sel, output logic [1:0] rdy, output logic [1:0] rv,
                           output logic [31:0] rd, output logic [3:0] mw, output logic [3:0] mr,
                           output logic [31:0] ma, output logic [31:0] md);
        if (sel == 0) begin
            rdy = if1.req_ready; rv = if1.rsp_valid; rd = if1.rsp_rdata;
            mw = if1.mem_write;  mr = if1.mem_read;  ma = if1.mem_addr; md = if1.mem_wdata;
        end else begin
            rdy = if3.req_ready; rv = if3.rsp_valid; rd = if3.rsp_rdata;
            mw = if3.mem_write;  mr = if3.mem_read;  ma = if3.mem_addr; md = if3.mem_wdata;
        end
    endtask

    // Advance to the next falling edge and settle any response due on either instance.
    task automatic tick();
        logic [1:0]  rdy, rv;
        logic [31:0] rd, ma, md;
        logic [3:0]  mw, mr;
        @(negedge clk);
        cycle++;
        for (int s = 0; s < 2; s++) begin
            get_out(s, rdy, rv, rd, mw, mr, ma, md);
            if (sb_q.size() > 0 && sb_q[0].sel == s && sb_q[0].due == cycle) begin
                chk("rsp_valid", 32'(rv), 32'(onehot(sb_q[0].port)));
                chk("rsp_rdata", rd, sb_q[0].rdata);
                void'(sb_q.pop_front());
            end else if (rv != 2'b00) begin
                chk("rsp_spurious", 32'(rv), 32'd0);
            end
        end
    endtask

    task automatic set_port(input int sel, input int port, input logic v, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] ws, input logic [3:0] rs);
        if (sel == 0) begin
            if1.req_valid[port] = v;
            if1.req_addr[port*32 +: 32]  = a;
            if1.req_wdata[port*32 +: 32] = d;
            if1.req_wstrb[port*4 +: 4]   = ws;
            if1.req_rstrb[port*4 +: 4]   = rs;
        end else begin
            if3.req_valid[port] = v;
            if3.req_addr[port*32 +: 32]  = a;
            if3.req_wdata[port*32 +: 32] = d;
            if3.req_wstrb[port*4 +: 4]   = ws;
            if3.req_rstrb[port*4 +: 4]   = rs;
        end
    endtask

    task automatic set_mrd(input int sel, input logic [31:0] d);
        if (sel == 0) if1.mem_rdata = d;
        else          if3.mem_rdata = d;
    endtask

    // Called just after a falling edge with the DUT idle and requests already driven.
    task automatic grant_cycle(input int sel, input int port, input logic [3:0] ew,
                               input logic [3:0] er, input logic [31:0] ea,
                               input logic [31:0] ed, input logic [31:0] erd);
        logic [1:0]  rdy, rv;
        logic [31:0] rd, ma, md;
        logic [3:0]  mw, mr;
        int          lat;
        lat = lat_of(sel);
        #1;
        get_out(sel, rdy, rv, rd, mw, mr, ma, md);
        chk("req_ready", 32'(rdy), 32'(onehot(port)));
        sb_q.push_back('{sel, port, erd, cycle + lat + 1});
        tick();
        for (int k = 0; k < lat; k++) begin
            get_out(sel, rdy, rv, rd, mw, mr, ma, md);
            chk("mem_write", 32'(mw), 32'(ew));
            chk("mem_read", 32'(mr), 32'(er));
            chk("mem_addr", ma, ea);
            chk("mem_wdata", md, ed);
            tick();
        end
        get_out(sel, rdy, rv, rd, mw, mr, ma, md);
        chk("mem_idle_resp", {8'd0, 4'(mw), 4'(mr), 16'd0} | ma, 32'd0);
        chk("ready_in_resp", 32'(rdy), 32'd0);
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        logic active;
        active = (v.wstrb != 4'd0) || (v.rstrb != 4'd0);
        set_mrd(v.sel, v.mrd);
        set_port(v.sel, v.port, 1'b1, v.addr, v.wdata, v.wstrb, v.rstrb);
        grant_cycle(v.sel, v.port, v.exp_w, v.exp_r,
                    active ? v.addr : 32'd0, active ? v.wdata : 32'd0, v.exp_rdata);
        set_port(v.sel, v.port, 1'b0, v.addr, v.wdata, v.wstrb, v.rstrb);
    endtask

    initial begin
        logic [1:0]  rdy, rv;
        logic [31:0] rd, ma, md;
        logic [3:0]  mw, mr;
        int          p;

        n_checks = 0;
        n_fail   = 0;
        cycle    = 0;

        //          sel port addr          wdata         ws    rs    mem_rdata     exp_w exp_r exp_rdata
        vecs[0] = '{0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 4'h0, 32'hAAAA_AAAA, 4'hF, 4'h0, 32'h0000_0000};
        vecs[1] = '{0, 1, 32'h0000_0020, 32'h0000_0000, 4'h0, 4'h3, 32'h1234_5678, 4'h0, 4'h3, 32'h0000_5678};
        vecs[2] = '{0, 0, 32'h0000_0030, 32'h0BAD_F00D, 4'hF, 4'hF, 32'hFFFF_FFFF, 4'hF, 4'h0, 32'h0000_0000};
        vecs[3] = '{0, 1, 32'h0000_0044, 32'h0000_0055, 4'h0, 4'h0, 32'hFFFF_FFFF, 4'h0, 4'h0, 32'h0000_0000};
        vecs[4] = '{0, 0, 32'h0000_0050, 32'h0000_0000, 4'h0, 4'hC, 32'hCAFE_F00D, 4'h0, 4'hC, 32'hCAFE_0000};
        vecs[5] = '{0, 1, 32'h0000_0054, 32'h0000_0000, 4'h0, 4'h5, 32'h1122_3344, 4'h0, 4'h5, 32'h0022_0044};
        vecs[6] = '{0, 0, 32'h0000_0008, 32'h0102_0304, 4'h6, 4'h0, 32'h9999_9999, 4'h6, 4'h0, 32'h0000_0000};
        vecs[7] = '{1, 0, 32'h0000_0300, 32'h0000_0000, 4'h0, 4'hF, 32'hCAFE_F00D, 4'h0, 4'hF, 32'hCAFE_F00D};
        vecs[8] = '{1, 1, 32'h0000_0304, 32'h0000_0000, 4'h0, 4'hF, 32'h0BAD_C0DE, 4'h0, 4'hF, 32'h0BAD_C0DE};
        vecs[9] = '{1, 0, 32'h0000_0308, 32'hA5A5_A5A5, 4'h3, 4'hF, 32'h7777_7777, 4'h3, 4'h0, 32'h0000_0000};

        nrst = 1'b1;
        if1.req_valid = 2'b11; if1.req_addr = '1; if1.req_wdata = '1;
        if1.req_wstrb = '1;    if1.req_rstrb = '1; if1.mem_rdata = '1;
        if3.req_valid = 2'b11; if3.req_addr = '1; if3.req_wdata = '1;
        if3.req_wstrb = '1;    if3.req_rstrb = '1; if3.mem_rdata = '1;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            get_out(s, rdy, rv, rd, mw, mr, ma, md);
            chk("reset_req_ready", 32'(rdy), 32'd0);
            chk("reset_rsp_valid", 32'(rv), 32'd0);
            chk("reset_rsp_rdata", rd, 32'd0);
            chk("reset_mem_strb", {24'd0, mw, mr}, 32'd0);
            chk("reset_mem_addr", ma, 32'd0);
            chk("reset_mem_wdata", md, 32'd0);
        end
        if1.req_valid = 2'b00; if1.req_wstrb = '0; if1.req_rstrb = '0;
        if3.req_valid = 2'b00; if3.req_wstrb = '0; if3.req_rstrb = '0;
        nrst = 1'b0;
        tick();

        // Vectors 7 and 8 run back to back, so their responses land five cycles apart.
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Pointer is now 1 on the slow instance; reset it in the middle of a port-1 read.
        set_mrd(1, 32'h7777_7777);
        set_port(1, 1, 1'b1, 32'h0000_0400, 32'd0, 4'h0, 4'hF);
        #1;
        get_out(1, rdy, rv, rd, mw, mr, ma, md);
        chk("midrst_grant", 32'(rdy), 32'(onehot(1)));
        tick();
        tick();
        get_out(1, rdy, rv, rd, mw, mr, ma, md);
        chk("midrst_access_read", 32'(mr), 32'hF);
        set_port(1, 1, 1'b0, 32'h0000_0400, 32'd0, 4'h0, 4'hF);
        nrst = 1'b1;
        #1;
        get_out(1, rdy, rv, rd, mw, mr, ma, md);
        chk("midrst_mem_read", 32'(mr), 32'd0);
        chk("midrst_mem_addr", ma, 32'd0);
        chk("midrst_rsp_valid", 32'(rv), 32'd0);
        repeat (2) tick();
        nrst = 1'b0;
        set_mrd(1, 32'h1357_9BDF);
        set_port(1, 0, 1'b1, 32'h0000_0500, 32'h0000_0000, 4'h0, 4'hF);
        set_port(1, 1, 1'b1, 32'h0000_0504, 32'h0000_0000, 4'h0, 4'hF);
        grant_cycle(1, 0, 4'h0, 4'hF, 32'h0000_0500, 32'h0000_0000, 32'h1357_9BDF);
        set_port(1, 0, 1'b0, 32'h0000_0500, 32'h0000_0000, 4'h0, 4'hF);
        set_port(1, 1, 1'b0, 32'h0000_0504, 32'h0000_0000, 4'h0, 4'hF);
        repeat (6) tick();

        // Both ports held valid from reset: grants must alternate 0, 1, 0, 1.
        set_mrd(0, 32'h8765_4321);
        set_port(0, 0, 1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF, 4'h0);
        set_port(0, 1, 1'b1, 32'h0000_0200, 32'h2222_2222, 4'h0, 4'hF);
        for (int g = 0; g < 4; g++) begin
            p = g % 2;
            grant_cycle(0, p,
                        (p == 0) ? 4'hF : 4'h0,
                        (p == 0) ? 4'h0 : 4'hF,
                        (p == 0) ? 32'h0000_0100 : 32'h0000_0200,
                        (p == 0) ? 32'h1111_1111 : 32'h2222_2222,
                        (p == 0) ? 32'h0000_0000 : 32'h8765_4321);
        end
        set_port(0, 0, 1'b0, 32'h0000_0100, 32'h1111_1111, 4'hF, 4'h0);
        set_port(0, 1, 1'b0, 32'h0000_0200, 32'h2222_2222, 4'h0, 4'hF);
        repeat (6) tick();

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the single-core memory hookup: arbitrates NUM_PORTS requestors onto one shared memory port with byte-lane write and read strobes, e.g. instruction fetch, data access and a future DMA port onto a unified memory.
- Adds valid/ready handshakes, round-robin fairness and configurable memory latency.
- Sits between core/master ports and the memory array.

Parameters:
- NUM_PORTS, 2, number of requestor ports (≥1).
- DATA_W, 32, data width; multiple of 8. STRB_W = DATA_W/8 is derived.
- ADDR_W, 32, address width.
- MEM_LAT, 1, cycles the memory signals are held before mem_rdata is sampled (≥1).

Ports:
- clk  input  1  clock, all state on rising edge.
- nrst  input  1  reset, asynchronous, active-high; the port name is kept from the codebase despite the high polarity.
- req_valid  input  NUM_PORTS  per-port request valid.
- req_ready  output  NUM_PORTS  per-port accept, one-hot or zero.
- req_addr  input  NUM_PORTS*ADDR_W  packed addresses; port i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_PORTS*DATA_W  packed write data.
- req_wstrb  input  NUM_PORTS*STRB_W  packed byte-lane write strobes.
- req_rstrb  input  NUM_PORTS*STRB_W  packed byte-lane read strobes.
- rsp_valid  output  NUM_PORTS  one-cycle completion pulse to the owning port.
- rsp_rdata  output  DATA_W  shared read data, valid only with rsp_valid.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_write  output  STRB_W  memory byte write enables.
- mem_read  output  STRB_W  memory byte read enables.
- mem_rdata  input  DATA_W  memory read data.

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE, the round-robin pointer is 0 (port 0 highest priority) and the latency counter is 0. Reset is asynchronous and may assert mid-access; the access is abandoned and no rsp_valid is issued.
- FSM has three states: IDLE, ACCESS and RESP.
- IDLE:
  - grant = first port with req_valid high, searching from the pointer upward with wrap.
  - req_ready[grant] is driven combinationally high in the same cycle; every other req_ready bit is 0.
  - On that edge, latch grant, addr, wdata, wstrb and rstrb, then go to ACCESS.
  - With no valid request, stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched request for exactly MEM_LAT cycles.
  - Write request (wstrb != 0): mem_write = wstrb and mem_read = 0. A write takes precedence when both strobes are nonzero.
  - Read request (wstrb == 0, rstrb != 0): mem_read = rstrb.
  - Both strobes zero: mem_write = mem_read = 0, no access, but the request still completes.
  - On the last ACCESS cycle, capture mem_rdata masked per lane by the effective read strobe; unread lanes are 0, and writes capture 0. Then go to RESP.
- RESP:
  - rsp_valid[grant] = 1 for exactly one cycle; rsp_rdata = captured data.
  - Pointer becomes (grant+1) mod NUM_PORTS; go to IDLE.
- Outside ACCESS, all mem_* outputs are 0. Outside RESP, rsp_valid = 0 and rsp_rdata is held at its last value.
- Latency: acceptance edge to rsp_valid is MEM_LAT+1 cycles. At most one outstanding request, so throughput is one request per MEM_LAT+2 cycles.
- Requestor rules:
  - Hold req_* stable while req_valid is high and not yet accepted.
  - req_valid may drop before acceptance (withdrawn requests are legal).
  - The requestor must always accept rsp_valid; there is no response backpressure.
- Simultaneous requests are resolved only by the pointer, so no port waits more than NUM_PORTS-1 grants.
- NUM_PORTS = 1 degenerates to a pass-through with the same timing.

Test Plan:
- Reset and single write: with MEM_LAT=1, port0 writes addr 0x10, data 0xDEADBEEF, wstrb 0xF. Response: req_ready[0] in the same cycle; mem_write=0xF, mem_addr=0x10 for 1 cycle; rsp_valid[0] 2 cycles after acceptance; rsp_rdata=0.
- Read with partial strobes: port1 reads with rstrb 0x3 while mem_rdata=0x12345678. Response: mem_read=0x3; rsp_rdata=0x00005678; rsp_valid[1] only.
- Round robin: both ports hold req_valid continuously for 4 grants from reset. Response: grant order is 0, 1, 0, 1, and each rsp_valid goes to the matching port.
- Latency parameter: with MEM_LAT=3, a read of a port reading 0xCAFEF00D. Response: mem_read asserted for exactly 3 cycles; rsp_valid 4 cycles after acceptance; back-to-back throughput is one response per 5 cycles.
- Edge strobes:
  - wstrb=0xF with rstrb=0xF → write only, mem_read=0, rsp_rdata=0.
  - Both strobes 0 → no mem_* activity, rsp_valid still issued.
- Reset mid-ACCESS: with MEM_LAT=3, assert nrst in the 2nd ACCESS cycle. Response: all outputs 0 immediately (asynchronous), no rsp_valid afterward, and the next grant goes to port 0.
